// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-level AXI-stream arbiter.
package axis_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PKT   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set request strictly after 'last', wrapping modulo n (n <= 8).
  function automatic int unsigned rr_next(input logic [7:0] req,
                                          input int unsigned last,
                                          input int unsigned n);
    int unsigned pick;
    int unsigned idx;
    logic [2:0]  idx3;
    pick = last;
    for (int unsigned k = n; k > 0; k--) begin
      idx  = (last + k) % n;
      idx3 = 3'(idx);
      if (req[idx3]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage registered stream output; loads whenever empty or drained downstream.
module axis_out_reg #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned SrcWidth  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_valid,
  input  logic [DataWidth-1:0] ld_data,
  input  logic                 ld_last,
  input  logic [SrcWidth-1:0]  ld_src,
  input  logic                 m_ready,
  output logic [DataWidth-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_last,
  output logic [SrcWidth-1:0]  m_src,
  output logic                 load_en
);

  assign load_en = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_src   <= '0;
    end else if (load_en) begin
      m_valid <= ld_valid;
      m_last  <= ld_valid && ld_last;
      if (ld_valid) begin
        m_data <= ld_data;
        m_src  <= ld_src;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-locked round-robin arbiter feeding one registered AXI-stream output;
// over-long packets are cut at MAX_BEATS and their tail is drained.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned MAX_BEATS = 4096,
  parameter int unsigned SrcWidth  = clog2_min1(NUM_SRC),
  parameter int unsigned CntWidth  = $clog2(MAX_BEATS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC*DataWidth-1:0] s_data,
  input  logic [NUM_SRC-1:0]           s_valid,
  input  logic [NUM_SRC-1:0]           s_last,
  output logic [NUM_SRC-1:0]           s_ready,
  output logic [DataWidth-1:0]         m_data,
  output logic                         m_valid,
  output logic                         m_last,
  input  logic                         m_ready,
  output logic [SrcWidth-1:0]          m_src,
  output logic [SrcWidth-1:0]          grant,
  output logic                         busy,
  output logic                         trunc
);

  arb_state_e           state;
  logic [SrcWidth-1:0]  grant_q;
  logic [SrcWidth-1:0]  last_grant;
  logic [CntWidth-1:0]  beat_cnt;
  logic                 trunc_q;

  logic [DataWidth-1:0] sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 gnt_ready;
  logic                 accept;
  logic                 at_limit;
  logic                 load_en;
  logic [7:0]           req8;

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q == SrcWidth'(i)) begin
        sel_data  = s_data[i*DataWidth +: DataWidth];
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
      end
    end
  end

  // DRAIN swallows the tail independently of downstream backpressure.
  always_comb begin
    gnt_ready = 1'b0;
    if (!rst) begin
      if (state == PKT)        gnt_ready = load_en;
      else if (state == DRAIN) gnt_ready = 1'b1;
    end
  end

  always_comb begin
    s_ready = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q == SrcWidth'(i)) s_ready[i] = gnt_ready;
    end
  end

  always_comb begin
    req8 = '0;
    req8[NUM_SRC-1:0] = s_valid;
  end

  assign accept   = sel_valid && gnt_ready;
  assign at_limit = (beat_cnt == CntWidth'(MAX_BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_q    <= '0;
      last_grant <= SrcWidth'(NUM_SRC - 1);
      beat_cnt   <= '0;
      trunc_q    <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|s_valid) begin
            grant_q <= SrcWidth'(rr_next(req8, 32'(last_grant), NUM_SRC));
            state   <= PKT;
          end
        end
        PKT: begin
          if (accept) begin
            if (sel_last) begin
              last_grant <= grant_q;
              beat_cnt   <= '0;
              state      <= IDLE;
            end else if (at_limit) begin
              trunc_q <= 1'b1;
              state   <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (accept && sel_last) begin
            last_grant <= grant_q;
            beat_cnt   <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_out_reg #(
    .DataWidth(DataWidth),
    .SrcWidth (SrcWidth)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .ld_valid(accept && (state == PKT)),
    .ld_data (sel_data),
    .ld_last (sel_last || at_limit),
    .ld_src  (grant_q),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_src   (m_src),
    .load_en (load_en)
  );

  assign grant = grant_q;
  assign busy  = (state != IDLE);
  assign trunc = trunc_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Scoreboard bench: packet-level round-robin model predicts the output beat stream.
module tb_axis_pkt_arbiter;

  localparam int NS = 2;
  localparam int DW = 16;
  localparam int MB = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic [0:0]    s;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [NS*DW-1:0] s_data;
  logic [NS-1:0]  s_valid, s_last, s_ready;
  logic [DW-1:0]  m_data;
  logic           m_valid, m_last, m_ready;
  logic [0:0]     m_src, grant;
  logic           busy, trunc;

  axis_pkt_arbiter #(
    .DataWidth(DW),
    .NUM_SRC  (NS),
    .MAX_BEATS(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .m_src(m_src), .grant(grant), .busy(busy), .trunc(trunc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // driver state
  logic [DW-1:0] dq [NS][$];
  bit            lq [NS][$];
  bit            vld [NS];
  bit            start [NS];
  logic [NS-1:0] fire = '0;
  int            fire_cnt [NS];
  int            cyc = 0;
  bit            gap_en = 1'b0;
  bit            rand_ready = 1'b0;
  bit            mr_q [$];

  // model state
  int            plen [NS][$];
  logic [DW-1:0] pbase [NS][$];
  beat_t         exp_q [$];
  int            model_last = NS - 1;
  int            trunc_exp = 0;
  int            trunc_seen = 0;

  // monitor state
  bit            hold_pend = 1'b0;
  logic [17:0]   hold_val;
  bit            rec = 1'b0;
  int            t_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic add_pkt(input int src, input int len, input logic [DW-1:0] base);
    for (int b = 0; b < len; b++) begin
      dq[src].push_back(base + DW'(b));
      lq[src].push_back(b == len - 1);
    end
    plen[src].push_back(len);
    pbase[src].push_back(base);
  endtask

  // Serve pending packets in round-robin order; long packets are cut at MB beats.
  task automatic predict();
    int c, len;
    bit found;
    logic [DW-1:0] base;
    beat_t e;
    while (plen[0].size() > 0 || plen[1].size() > 0) begin
      found = 1'b0;
      c = model_last;
      for (int k = 1; k <= NS; k++) begin
        if (!found && plen[(model_last + k) % NS].size() > 0) begin
          c = (model_last + k) % NS;
          found = 1'b1;
        end
      end
      len  = plen[c].pop_front();
      base = pbase[c].pop_front();
      for (int b = 0; b < len && b < MB; b++) begin
        e.d = base + DW'(b);
        e.l = (b == len - 1) || (b == MB - 1);
        e.s = 1'(c);
        exp_q.push_back(e);
      end
      if (len > MB) trunc_exp++;
      model_last = c;
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || dq[0].size() > 0 || dq[1].size() > 0 || busy || m_valid)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_complete"}, 32'(n < budget), 32'd1);
    repeat (2) @(negedge clk);
    check({name, "_trunc_count"}, trunc_seen, trunc_exp);
    #1;
  endtask

  // driver: beats leave the queues only on a sampled handshake
  initial begin
    s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b1;
    for (int i = 0; i < NS; i++) begin vld[i] = 1'b0; start[i] = 1'b1; fire_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NS; i++) begin
        if (fire[i]) begin
          fire_cnt[i]++;
          if (dq[i].size() > 0) begin
            start[i] = lq[i][0];
            void'(dq[i].pop_front());
            void'(lq[i].pop_front());
          end
          vld[i] = 1'b0;
        end
        if (dq[i].size() == 0) vld[i] = 1'b0;
        else if (!vld[i]) vld[i] = start[i] || !gap_en || ($urandom_range(3) != 0);
        s_valid[i]         = vld[i];
        s_data[i*DW +: DW] = (dq[i].size() > 0) ? dq[i][0] : '0;
        s_last[i]          = (dq[i].size() > 0) ? lq[i][0] : 1'b0;
      end
      if (mr_q.size() > 0) m_ready = mr_q.pop_front();
      else m_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
      #3;
      fire = s_valid & s_ready;
    end
  end

  // monitor
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (hold_pend) begin
          check("hold_valid", 32'(m_valid), 32'd1);
          check("hold_beat", 32'({m_last, m_src, m_data}), 32'(hold_val));
        end
        hold_pend = m_valid && !m_ready;
        hold_val  = {m_last, m_src, m_data};
        check("s_ready_nongrant", 32'(s_ready & ~(2'b01 << grant)), 32'd0);
        if (!busy) check("s_ready_idle", 32'(s_ready), 32'd0);
        else if (!m_valid || m_ready) check("s_ready_grant", 32'(s_ready[grant]), 32'd1);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL extra_beat: got beat 0x%0h src %0d, expected no beat", m_data, m_src);
          end else begin
            e = exp_q.pop_front();
            check("beat", 32'({m_last, m_src, m_data}), 32'({e.l, e.s, e.d}));
          end
          if (rec) t_q.push_back(cyc);
        end
        if (trunc) trunc_seen++;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  initial begin
    int f0, n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last",  32'(m_last),  32'd0);
    check("rst_m_data",  32'(m_data),  32'd0);
    check("rst_m_src",   32'(m_src),   32'd0);
    check("rst_grant",   32'(grant),   32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_trunc",   32'(trunc),   32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;

    // two sources contending: 0,1,0 with one bubble per packet
    rec = 1'b1; t_q.delete();
    add_pkt(0, 3, 16'h0A01);
    add_pkt(1, 3, 16'h0B01);
    add_pkt(0, 3, 16'h0C01);
    predict();
    wait_done("rr_basic", 200);
    rec = 1'b0;
    if (t_q.size() >= 4) begin
      check("rr_gap01", t_q[1] - t_q[0], 1);
      check("rr_gap12", t_q[2] - t_q[1], 1);
      check("rr_bubble", t_q[3] - t_q[2], 2);
    end else check("rr_beat_times", t_q.size(), 4);

    // backpressure holds the output register
    @(negedge clk); #1;
    mr_q = '{1, 1, 1, 0, 0, 1};
    add_pkt(0, 3, 16'h1111);
    exp_q.push_back('{d: 16'h1111, l: 1'b0, s: 1'b0});
    exp_q.push_back('{d: 16'h2222, l: 1'b0, s: 1'b0});
    exp_q.push_back('{d: 16'h3333, l: 1'b1, s: 1'b0});
    dq[0][1] = 16'h2222; dq[0][2] = 16'h3333;
    void'(plen[0].pop_front()); void'(pbase[0].pop_front());
    model_last = 0;
    wait_done("backpressure", 200);

    // single-beat packets from src1
    @(negedge clk); #1;
    rec = 1'b1; t_q.delete();
    for (int i = 0; i < 4; i++) add_pkt(1, 1, 16'h4400 + 16'(i));
    predict();
    wait_done("single_beat", 200);
    rec = 1'b0;
    if (t_q.size() == 4) begin
      for (int i = 1; i < 4; i++) check("single_beat_spacing", t_q[i] - t_q[i-1], 2);
    end else check("single_beat_count", t_q.size(), 4);

    // truncation at MB beats, then src1 granted
    @(negedge clk); #1;
    add_pkt(0, 6, 16'h8001);
    add_pkt(1, 2, 16'h9001);
    predict();
    wait_done("truncate", 300);

    // s_last coincident with the limit: normal completion
    @(negedge clk); #1;
    add_pkt(0, 4, 16'hA001);
    add_pkt(1, 1, 16'hB001);
    predict();
    wait_done("limit_last", 300);

    // randomized traffic with gaps and backpressure
    @(negedge clk); #1;
    gap_en = 1'b1; rand_ready = 1'b1;
    for (int i = 0; i < 30; i++)
      add_pkt($urandom_range(1), $urandom_range(6, 1), 16'($urandom));
    predict();
    wait_done("random", 4000);
    gap_en = 1'b0; rand_ready = 1'b0;

    // reset in the middle of a packet
    @(negedge clk); #1;
    f0 = fire_cnt[0];
    add_pkt(0, 5, 16'hC001);
    predict();
    n = 0;
    while (fire_cnt[0] < f0 + 3 && n < 50) begin @(negedge clk); #1; n++; end
    check("midrst_reach", 32'(n < 50), 32'd1);
    rst = 1'b1;
    for (int i = 0; i < NS; i++) begin
      dq[i].delete(); lq[i].delete(); plen[i].delete(); pbase[i].delete();
      vld[i] = 1'b0; start[i] = 1'b1;
    end
    s_valid = '0;
    exp_q.delete();
    trunc_exp = 0; trunc_seen = 0;
    model_last = NS - 1;
    @(negedge clk); #1;
    rst = 1'b0;
    #3;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_m_last",  32'(m_last),  32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    check("midrst_busy",    32'(busy),    32'd0);
    @(negedge clk); #1;
    add_pkt(1, 2, 16'hD001);
    add_pkt(0, 2, 16'hE001);
    predict();
    wait_done("post_reset", 200);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter.md
Name: axis_pkt_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single write side of the 4096-deep stream FIFO wrapper among NUM_SRC AXI-stream requesters.
- A grant is locked for a whole packet (until s_last). The output is a registered stream that feeds the FIFO's s_data/s_valid/s_last, with m_ready driven from the FIFO's ready/!full.
- Packets longer than MAX_BEATS are force-terminated so the FIFO never holds an unbounded packet.

Parameters:
- DataWidth, 16, beat width in bits.
- NUM_SRC, 2, number of requesters (2..8).
- MAX_BEATS, 4096, max beats per packet before forced termination (>=2).
- SrcWidth, max(1,$clog2(NUM_SRC)), width of the source id.
- CntWidth, $clog2(MAX_BEATS+1), beat counter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  NUM_SRC*DataWidth  requester data; source i occupies bits [i*DataWidth +: DataWidth].
- s_valid  in  NUM_SRC  per-source valid.
- s_last  in  NUM_SRC  per-source end of packet.
- s_ready  out  NUM_SRC  per-source ready, combinational.
- m_data  out  DataWidth  granted beat, registered.
- m_valid  out  1  output valid, registered.
- m_last  out  1  output end of packet, registered; also set on forced termination.
- m_ready  in  1  downstream (FIFO) ready.
- m_src  out  SrcWidth  source id of the current m_data beat.
- grant  out  SrcWidth  currently granted source; holds its value in IDLE.
- busy  out  1  high when state != IDLE.
- trunc  out  1  one-cycle pulse when a packet is force-terminated.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - s_ready=0, m_valid=0, m_last=0, m_data=0, m_src=0, grant=0, busy=0, trunc=0.
  - beat_cnt=0, last_grant=NUM_SRC-1, so source 0 has first priority.
- Reset mid-packet: the packet is abandoned. m_valid is 0 the cycle after rst. No m_last is emitted for the partial packet.
- Output register:
  - load_en = !m_valid || m_ready.
  - On load_en, the register takes the accepted beat, or clears m_valid if no beat was accepted that cycle.
  - m_data, m_last and m_src are stable while m_valid && !m_ready.
- Beat acceptance: accept = s_valid[grant] && s_ready[grant]. s_ready is one-hot or zero, and only s_ready[grant] can be high.
- State IDLE:
  - s_ready=0.
  - If any s_valid is set, choose the first set bit searching from last_grant+1 upward, with modulo-NUM_SRC wrap.
  - Register grant and go to PKT. If no s_valid is set, stay in IDLE.
  - The search uses s_valid only; s_last is ignored in IDLE.
- State PKT:
  - s_ready[grant] = load_en.
  - On accept with s_last[grant]=1: emit the beat with m_last=1, set last_grant=grant, beat_cnt=0, go to IDLE.
  - On accept with s_last=0 and beat_cnt==MAX_BEATS-1: emit the beat with m_last=1, pulse trunc, go to DRAIN.
  - Any other accept: beat_cnt+1.
- State DRAIN:
  - s_ready[grant]=1 regardless of m_ready. Beats are discarded and not loaded into the output register.
  - On accept with s_last=1: last_grant=grant, beat_cnt=0, go to IDLE.
- Latency:
  - A request seen in IDLE in cycle 0 is granted at the end of cycle 0.
  - The first beat is accepted in cycle 1 if m_ready permits, and m_valid is high in cycle 2.
  - Back-to-back beats then proceed at 1 beat/cycle.
  - Each packet costs exactly one IDLE arbitration bubble on the input side.
- Single-beat packet: s_last on the first beat returns to IDLE immediately with beat_cnt unchanged at 0.
- Simultaneous events:
  - A requester that drops s_valid mid-packet keeps the grant, with no timeout.
  - Requests from other sources during PKT/DRAIN are ignored until IDLE.
  - When MAX_BEATS is reached on the same beat as s_last=1, the packet completes normally: no trunc, no DRAIN.
- Full FIFO (m_ready=0 held): the output register holds, s_ready=0 in PKT, and no beat is lost or duplicated.

Decomposition:
- Package axis_arb_pkg holds:
  - the state encoding IDLE=2'd0, PKT=2'd1, DRAIN=2'd2;
  - a clog2-min-1 function for SrcWidth;
  - a round-robin next-index function.
- One sub-module, axis_out_reg: a single-stage output register with the load_en rule above. The arbiter FSM and beat counter stay in the top.

Test Plan:
- Reset, then s_valid=2'b11 with both sources sending 3-beat packets (src0: 0x0A01..0x0A03, src1: 0x0B01..0x0B03), m_ready=1.
  - Output is 0x0A01,0x0A02,0x0A03(last), m_src=0, then one bubble, then 0x0B01..0x0B03(last), m_src=1.
  - grant alternates 0,1,0 thereafter.
- Backpressure: m_ready toggling 1,0,0,1 during a src0 packet 0x1111,0x2222,0x3333.
  - m_data is held while m_ready=0.
  - Exactly three beats are transferred, in order; the s_ready[0] pattern matches load_en.
- Single-beat packets from src1 only, s_last=1 every beat.
  - One beat every 2 cycles, m_last=1 on each, grant stays 1, trunc stays 0.
- MAX_BEATS=4 build, src0 sends 6 beats with s_last on beat 6.
  - Beats 1-4 are output, beat 4 with m_last=1; trunc pulses one cycle.
  - Beats 5-6 are consumed and not output; the next packet from src1 is granted after that.
- Reset asserted in cycle 3 of a 5-beat packet.
  - m_valid=0 and s_ready=0 the next cycle, state IDLE, last_grant=NUM_SRC-1.
  - The next request from src0 wins even if src1 also requests.
- MAX_BEATS=4 build with s_last coincident on beat 4.
  - m_last=1, trunc=0, and the FSM returns to IDLE rather than entering DRAIN.
